// File: rtl/jtcps2_eeprom_slave.sv
// jtcps2_eeprom_slave: 93C46-style 64x16 serial EEPROM responder with NVRAM byte dump port.
// Define JTCPS2_EEPROM_DUMP_EN to enable the dump port; otherwise it reads 0 and ignores writes.
module jtcps2_eeprom_slave #(
   parameter int AW       = 6,
   parameter int DW       = 16,
   parameter int BUSY_CYC = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scs,
   input  logic       sclk,
   input  logic       sdi,
   output logic       sdo,
   input  logic [6:0] dump_addr,
   input  logic       dump_we,
   input  logic [7:0] dump_din,
   output logic [7:0] dump_dout,
   output logic       dump_flag
);
   localparam int CW = $clog2(DW);
   localparam int BW = $clog2(BUSY_CYC + 1);
   typedef enum logic [2:0] {IDLE, OPC, ADDR, RD, WD, WAITCS} state_t;

   state_t        state_q, state_d;
   logic          sclk_q, wr_en_q, wr_en_d, sdo_q, sdo_d, bulk_q, bulk_d, flag_q, flag_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    opc_q, opc_d;
   logic [AW-1:0] addr_q, addr_d, bidx_q, bidx_d, waddr;
   logic [DW-1:0] sr_q, sr_d, bdat_q, bdat_d, wdata;
   logic [BW-1:0] busy_q, busy_d;
   logic [7:0]    dout_q, dout_d;
   logic          rise, commit, is_bulk, wen;
`ifdef JTCPS2_EEPROM_DUMP_EN
   logic [DW-1:0] nvram [2**AW];
`else
   logic [DW-1:0] nvram [2**AW] = '{default: '1};
   logic          dump_unused;
   assign dump_unused = ^{dump_we, dump_din, dump_addr};
`endif

   assign sdo       = sdo_q;
   assign dump_dout = dout_q;
   assign dump_flag = flag_q;

   // command decode, shift registers, commit/bulk sequencing, NVRAM write port and sdo
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opc_d   = opc_q;
      addr_d  = addr_q;
      sr_d    = sr_q;
      wr_en_d = wr_en_q;
      bulk_d  = bulk_q;
      bidx_d  = bidx_q;
      bdat_d  = bdat_q;
      rise    = sclk & ~sclk_q & scs;
      is_bulk = opc_q == 2'b00;
      commit  = state_q == WAITCS && !scs && wr_en_q && busy_q == '0 &&
                !(is_bulk && addr_q[AW-1] == addr_q[AW-2]);
      if (!scs) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (rise) begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = sdi ? OPC : IDLE;
            end
            OPC: begin
               opc_d   = {opc_q[0], sdi};
               cnt_d   = cnt_q == CW'(1) ? '0 : cnt_q + 1'b1;
               state_d = cnt_q == CW'(1) ? ADDR : OPC;
            end
            ADDR: begin
               addr_d = {addr_q[AW-2:0], sdi};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(AW-1)) begin
                  cnt_d   = '0;
                  state_d = opc_q == 2'b10 ? RD :
                            (opc_q == 2'b01 || (is_bulk && addr_d[AW-1:AW-2] == 2'b01)) ? WD : WAITCS;
                  sr_d    = nvram[addr_d];
                  if (is_bulk && addr_d[AW-1] == addr_d[AW-2]) wr_en_d = addr_d[AW-1];
               end
            end
            RD: begin
               sr_d  = {sr_q[DW-2:0], 1'b0};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DW-1)) begin
                  cnt_d  = '0;
                  addr_d = addr_q + 1'b1;
                  sr_d   = nvram[addr_d];
               end
            end
            WD: begin
               sr_d    = {sr_q[DW-2:0], sdi};
               cnt_d   = cnt_q == CW'(DW-1) ? '0 : cnt_q + 1'b1;
               state_d = cnt_q == CW'(DW-1) ? WAITCS : WD;
            end
            default: cnt_d = cnt_q;
         endcase
      end
      if (commit && is_bulk) begin
         bulk_d = 1'b1;
         bidx_d = '0;
         bdat_d = addr_q[AW-2] ? sr_q : '1;
      end else if (bulk_q) begin
         bidx_d = bidx_q + 1'b1;
         bulk_d = bidx_q != '1;
      end
      wen    = bulk_q | (commit & ~is_bulk);
      waddr  = bulk_q ? bidx_q : addr_q;
      wdata  = bulk_q ? bdat_q : opc_q[1] ? '1 : sr_q;
      busy_d = commit ? BW'(BUSY_CYC) : busy_q == '0 ? '0 : busy_q - 1'b1;
      sdo_d  = state_d == RD ? (rise ? (state_q == RD ? sr_q[DW-1] : 1'b0) : sdo_q) :
               (state_d == IDLE && scs) ? busy_d == '0 : 1'b1;
`ifdef JTCPS2_EEPROM_DUMP_EN
      flag_d = commit | (flag_q & ~dump_we);
      dout_d = dump_addr[0] ? nvram[dump_addr[AW:1]][DW-1:8] : nvram[dump_addr[AW:1]][7:0];
      if (dump_we && !wen && !commit) begin
         wen   = 1'b1;
         waddr = dump_addr[AW:1];
         wdata = dump_addr[0] ? {dump_din, nvram[dump_addr[AW:1]][7:0]} :
                                {nvram[dump_addr[AW:1]][DW-1:8], dump_din};
      end
`else
      flag_d = 1'b0;
      dout_d = '0;
`endif
   end

   // control and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sclk_q  <= 1'b0;
         cnt_q   <= '0;
         opc_q   <= '0;
         addr_q  <= '0;
         sr_q    <= '0;
         wr_en_q <= 1'b0;
         bulk_q  <= 1'b0;
         bidx_q  <= '0;
         bdat_q  <= '0;
         busy_q  <= '0;
         sdo_q   <= 1'b1;
         flag_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         sclk_q  <= sclk;
         cnt_q   <= cnt_d;
         opc_q   <= opc_d;
         addr_q  <= addr_d;
         sr_q    <= sr_d;
         wr_en_q <= wr_en_d;
         bulk_q  <= bulk_d;
         bidx_q  <= bidx_d;
         bdat_q  <= bdat_d;
         busy_q  <= busy_d;
         sdo_q   <= sdo_d;
         flag_q  <= flag_d;
         dout_q  <= dout_d;
      end
   end

   // NVRAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wen) nvram[waddr] <= wdata;
   end
endmodule

// File: tb/tb_jtcps2_eeprom_slave.sv
// tb_jtcps2_eeprom_slave: directed plus random serial commands against a word-array EEPROM model.
module tb_jtcps2_eeprom_slave;
   logic       clk = 1'b0, rst = 1'b1, scs = 1'b0, sclk = 1'b0, sdi = 1'b0, dump_we = 1'b0;
   logic       sdo, dump_flag;
   logic [6:0] dump_addr = '0;
   logic [7:0] dump_din = '0, dump_dout;
   int         checks = 0, failures = 0, cyc = 0, last_desel = 0, cc = 0;
   logic [15:0] mem_m [64];
   bit         wr_en_m = 0, busy_m = 0, flag_m = 0;

   jtcps2_eeprom_slave dut (
      .clk(clk), .rst(rst), .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo),
      .dump_addr(dump_addr), .dump_we(dump_we), .dump_din(dump_din),
      .dump_dout(dump_dout), .dump_flag(dump_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #10000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic b, output logic o);
      sdi = b;
      sclk = 1'b0;
      tick(2);
      sclk = 1'b1;
      tick(3);
      o = sdo;
   endtask

   task automatic start(input logic [1:0] op, input logic [5:0] a, output logic o);
      scs = 1'b1;
      sclk = 1'b0;
      tick(2);
      repeat ($urandom_range(0, 2)) send(1'b0, o);
      send(1'b1, o);
      for (int i = 1; i >= 0; i--) send(op[i], o);
      for (int i = 5; i >= 0; i--) send(a[i], o);
   endtask

   task automatic desel();
      sclk = 1'b0;
      tick(1);
      scs = 1'b0;
      last_desel = cyc;
      tick(3);
   endtask

   task automatic commit_m(input bit all, input logic [5:0] a, input logic [15:0] d);
      if (wr_en_m && !busy_m) begin
         if (all) for (int i = 0; i < 64; i++) mem_m[i] = d;
         else mem_m[a] = d;
         busy_m = 1;
         flag_m = 1;
         cc = last_desel;
      end
   endtask

   task automatic check_ready(input string tag);
      int t;
      logic exp_flag;
      scs = 1'b1;
      sclk = 1'b0;
      tick(3);
      check({tag, " busy"}, sdo, busy_m ? 0 : 1);
      if (busy_m) begin
         t = 0;
         while (sdo !== 1'b1 && t < 400) begin
            tick(1);
            t++;
         end
         check({tag, " busylen"}, 32'((cyc - cc >= 250) && (cyc - cc <= 262)), 1);
         busy_m = 0;
      end
`ifdef JTCPS2_EEPROM_DUMP_EN
      exp_flag = flag_m;
`else
      exp_flag = 1'b0;
`endif
      check({tag, " flag"}, dump_flag, exp_flag);
      scs = 1'b0;
      tick(2);
   endtask

   task automatic op_write(input logic [5:0] a, input logic [15:0] d, input bit wait_ready);
      logic o;
      start(2'b01, a, o);
      for (int i = 15; i >= 0; i--) send(d[i], o);
      send(1'($urandom_range(0, 1)), o);
      desel();
      commit_m(0, a, d);
      if (wait_ready) check_ready("write");
   endtask

   task automatic op_erase(input logic [5:0] a);
      logic o;
      start(2'b11, a, o);
      desel();
      commit_m(0, a, 16'hFFFF);
      check_ready("erase");
   endtask

   task automatic op_ew(input bit en);
      logic o;
      start(2'b00, en ? 6'b110000 : 6'b000000, o);
      desel();
      wr_en_m = en;
      check_ready("ewen/ewds");
   endtask

   task automatic op_eral();
      logic o;
      start(2'b00, 6'b100000, o);
      desel();
      commit_m(1, '0, 16'hFFFF);
      check_ready("eral");
   endtask

   task automatic op_wral(input logic [15:0] d);
      logic o;
      start(2'b00, 6'b010000, o);
      for (int i = 15; i >= 0; i--) send(d[i], o);
      desel();
      commit_m(1, '0, d);
      check_ready("wral");
   endtask

   task automatic op_read(input logic [5:0] a, input int nw);
      logic o;
      logic [15:0] w;
      start(2'b10, a, o);
      check("rd dummy", o, 0);
      for (int k = 0; k < nw; k++) begin
         for (int i = 15; i >= 0; i--) begin
            send(1'($urandom_range(0, 1)), o);
            w[i] = o;
         end
         check("rd word", w, mem_m[6'(int'(a) + k)]);
      end
      desel();
   endtask

   task automatic dump_wr(input logic [6:0] a, input logic [7:0] d);
      dump_addr = a;
      dump_din = d;
      dump_we = 1'b1;
      tick(1);
      dump_we = 1'b0;
`ifdef JTCPS2_EEPROM_DUMP_EN
      if (a[0]) mem_m[a[6:1]][15:8] = d;
      else mem_m[a[6:1]][7:0] = d;
      flag_m = 0;
`endif
   endtask

   task automatic dump_rd(input logic [6:0] a);
      logic [7:0] e;
      dump_addr = a;
      tick(2);
`ifdef JTCPS2_EEPROM_DUMP_EN
      e = a[0] ? mem_m[a[6:1]][15:8] : mem_m[a[6:1]][7:0];
`else
      e = 8'h00;
`endif
      check("dump_dout", dump_dout, e);
   endtask

   initial begin
      logic o;
      logic [5:0] a;
      logic [15:0] d;
      for (int i = 0; i < 64; i++) mem_m[i] = 16'hFFFF;
      tick(3);
      check("reset sdo", sdo, 1);
      check("reset flag", dump_flag, 0);
      check("reset dout", dump_dout, 0);
      rst = 1'b0;
      tick(2);
`ifdef JTCPS2_EEPROM_DUMP_EN
      for (int i = 0; i < 128; i++) dump_wr(7'(i), 8'hFF);
`endif
      op_ew(1);
      op_write(6'd5, 16'h1234, 1);
      op_read(6'd5, 2);
      op_ew(0);
      op_write(6'd5, 16'hBEEF, 1);
      op_read(6'd5, 1);
      op_ew(1);
      op_write(6'd63, 16'($urandom), 1);
      op_write(6'd0, 16'($urandom), 1);
      op_read(6'd63, 2);
      start(2'b01, 6'd9, o);
      for (int i = 0; i < 9; i++) send(1'($urandom_range(0, 1)), o);
      desel();
      check_ready("abort");
      op_read(6'd9, 1);
      op_write(6'd7, 16'($urandom), 0);
      op_write(6'd8, 16'($urandom), 1);
      op_read(6'd7, 2);
      op_eral();
      op_read(6'($urandom), 3);
      repeat (30) begin
         a = 6'($urandom);
         d = 16'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2: op_write(a, d, 1);
            3, 4: op_read(a, $urandom_range(1, 3));
            5: op_erase(a);
            6: op_ew($urandom_range(0, 3) != 0);
            7: op_wral(d);
            8: begin
               dump_wr(7'($urandom), 8'($urandom));
               dump_rd(7'($urandom));
            end
            default: op_read(a, 1);
         endcase
      end
      op_ew(1);
      op_write(6'd1, 16'h5A5A, 1);
      dump_wr(7'd0, 8'h0A);
      dump_wr(7'd1, 8'h0B);
      dump_rd(7'd0);
      dump_rd(7'd1);
      dump_rd(7'd2);
      check_ready("dump");
      op_read(6'd0, 2);
      start(2'b01, 6'd3, o);
      for (int i = 0; i < 5; i++) send(1'b1, o);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      check("rst mid-wd sdo", sdo, 1);
      desel();
      wr_en_m = 0;
      busy_m = 0;
      flag_m = 0;
      op_read(6'd3, 1);
      op_write(6'd3, 16'h0F0F, 1);
      op_read(6'd3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
